// File: rtl/tff_down_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tff_down_counter_pkg
// Brief    : Shared types for the T-flip-flop down counter.
// Revision : 1.0  initial release
// ============================================================================
package tff_down_counter_pkg;

   // Operating mode selected on each clock edge. Priority is resolved by
   // the top level: load > wrap/count > hold.
   typedef enum logic [1:0] {
      MODE_HOLD  = 2'd0,
      MODE_COUNT = 2'd1,
      MODE_WRAP  = 2'd2,
      MODE_LOAD  = 2'd3
   } cnt_mode_e;

endpackage : tff_down_counter_pkg
`default_nettype wire

// File: rtl/tff_down_counter_tff_cell.sv
`default_nettype none
// ============================================================================
// Module   : tff_cell
// Brief    : Single T toggle flop with asynchronous active-high clear.
// Revision : 1.0  initial release
// ============================================================================
module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   output logic q
);

   logic q_q;

   // Toggle storage: flips when t is high, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= 1'b0;
      end else if (t) begin
         q_q <= ~q_q;
      end
   end

   assign q = q_q;

endmodule : tff_cell
`default_nettype wire

// File: rtl/tff_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tff_down_counter
// Brief    : Parameterised down counter built from T flip-flops, with
//            parallel load, optional auto-reload and cascade borrow.
// Revision : 1.0  initial release
// ============================================================================
module tff_down_counter
   import tff_down_counter_pkg::*;
#(
   parameter int WIDTH = 4             // counter width, must be >= 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             borrow,
   output logic             wrap
);

   logic [WIDTH-1:0] cnt_q;        // collected outputs of the toggle cells
   logic [WIDTH-1:0] reload_q;     // value re-entered on auto-reload wraps
   logic             wrap_q;
   cnt_mode_e        mode_d;
   logic [WIDTH-1:0] t_d;          // per-bit toggle enables
   logic             wrap_d;

   assign zero   = (cnt_q == '0);
   assign borrow = enable & ~load & zero;

   // Resolve the edge action: load beats counting, counting at zero is a wrap
   always_comb begin
      mode_d = MODE_HOLD;
      if (load) begin
         mode_d = MODE_LOAD;
      end else if (enable && zero) begin
         mode_d = MODE_WRAP;
      end else if (enable) begin
         mode_d = MODE_COUNT;
      end
   end

   // Toggle enables: ripple-borrow pattern when counting, q^target otherwise.
   // d is only looked at in load mode so an undriven d cannot leak into q.
   always_comb begin
      logic lower_zero;
      t_d        = '0;
      lower_zero = 1'b1;
      unique case (mode_d)
         MODE_LOAD: begin
            t_d = cnt_q ^ d;
         end
         MODE_WRAP: begin
            // q is all zeros here, so the toggle vector equals the target
            t_d = auto_reload ? (cnt_q ^ reload_q) : (cnt_q ^ {WIDTH{1'b1}});
         end
         MODE_COUNT: begin
            // bit i toggles when every lower bit is 0 (a borrow ripples up)
            for (int i = 0; i < WIDTH; i++) begin
               t_d[i]     = lower_zero;
               lower_zero = lower_zero & ~cnt_q[i];
            end
         end
         default: begin
            t_d = '0;
         end
      endcase
   end

   assign wrap_d = (mode_d == MODE_WRAP);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t_d[gi]),
            .q     (cnt_q[gi])
         );
      end
   endgenerate

   // Reload value is plain D storage, captured only on a load strobe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reload_q <= '0;
      end else if (load) begin
         reload_q <= d;
      end
   end

   // One-cycle wrap pulse, aligned with the reloaded or wrapped count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign q    = cnt_q;
   assign wrap = wrap_q;

endmodule : tff_down_counter
`default_nettype wire

// File: doc/tff_down_counter.md
Name: tff_down_counter

Overview:
- Synchronous, parameterised down counter built from T flip-flops; the counting-down counterpart of the team's 4-bit T-FF up counter.
- Adds parallel load, optional auto-reload, and a cascade borrow.
- Used as a countdown timer and divider: software or an FSM loads a value, and the block counts to zero and flags the wrap.
- Borrow output chains multiple instances into wider counters.

Parameters:
WIDTH, 4, counter width in bits (>=2)

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
enable  input  1  count-down qualifier; hold when low
load  input  1  parallel load strobe; captures d into counter and reload register
d  input  WIDTH  load value
auto_reload  input  1  1 = on wrap from 0, reload from reload register; 0 = free-run wrap to all-ones
q  output  WIDTH  current count
zero  output  1  combinational, q == 0
borrow  output  1  combinational, enable & ~load & (q == 0); cascade into next stage's enable
wrap  output  1  registered one-cycle pulse, asserted the cycle after the counter leaves 0 through counting

Behaviour:
- Reset (async, any time, including mid-count or mid-load):
  - q = 0, reload register = 0, wrap = 0.
  - zero = 1 while in reset; borrow follows its equation.
- Priority per clock edge: reset > load > enable > hold.
- load = 1 (enable ignored): q <= d, reload_reg <= d, wrap <= 0.
- load = 0, enable = 1, q != 0: q <= q - 1 (mod 2^WIDTH), wrap <= 0.
- load = 0, enable = 1, q == 0:
  - auto_reload = 1: q <= reload_reg.
  - auto_reload = 0: q <= all-ones.
  - In both cases wrap <= 1 for exactly one cycle.
- load = 0, enable = 0: q and reload_reg hold; wrap <= 0.
- Reload of 0 with auto_reload = 1: q stays 0 and wrap pulses on every enabled cycle (divide-by-1).
- Latency: q updates one clock after the qualifying edge. zero and borrow are combinational from q and the inputs. wrap is aligned with the q value already reloaded or wrapped.
- T-FF structure is mandatory:
  - Count mode: t[0] = enable; t[i] = enable & ~q[0] & ... & ~q[i-1].
  - Load and reload modes: t = q ^ target, where target = d on load, or reload_reg / all-ones at zero.
  - Each t is combinational and feeds one toggle flop per bit.
- reload_reg is plain D storage updated only by load.
- auto_reload is sampled on the wrap edge only; changing it mid-count has no other effect.
- No X propagation from d while load = 0.

Decomposition:
- No shared package needed; WIDTH is the only constant.
- One natural sub-module: tff_cell.
  - T toggle flop with async active-high reset to 0.
  - Ports: clk, reset, t, q.
  - Instantiated WIDTH times through a generate loop.
- Toggle-enable generation and reload mux stay in the top level.

Test Plan:
- Reset: assert reset mid-count at q = 9 between clock edges -> q = 0 and wrap = 0 immediately, without waiting for a clock edge; zero = 1.
- Load then count: load d = 5, then enable for 6 cycles -> q = 5,4,3,2,1,0,15. Wrap = 1 only in the cycle q = 15; borrow = 1 only while q = 0.
- Auto-reload: load d = 3, auto_reload = 1, enable held -> q = 3,2,1,0,3,2,1,0,3. Wrap pulses each time q returns to 3 (period 4).
- Load priority: q = 7, load = 1 with d = 12 and enable = 1 in the same cycle -> q = 12 next cycle, not 6; wrap = 0.
- Hold and edge cases:
  - enable = 0 for 5 cycles at q = 2 -> q stays 2 and wrap stays 0.
  - Load d = 0 with auto_reload = 1 and enable held -> q = 0 continuously, wrap = 1 every cycle.
- Cascade: two instances, low stage's borrow feeding high stage's enable, both loaded 0 -> first enabled edge gives {hi,lo} = 255. Low stage counts 15..0; high stage decrements only when the low stage wraps.
